// File: rtl/test_wave_gen_multi.sv
// test_wave_gen_multi: saw-up / saw-down / triangle / square test waveform with period-aligned mode switching.
// Square shape (mode 3) is built only when TWG_SQUARE_EN is defined; otherwise mode 3 runs as saw up.
`default_nettype none

module test_wave_gen_multi #(
  parameter int WIDTH = 10,
  parameter int MAX   = 639
) (
  input  logic             slowclock,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] wave,
  output logic             wrap,
  output logic [1:0]       mode_active
);

  typedef enum logic [1:0] {
    SAW_UP = 2'd0,
    SAW_DN = 2'd1,
    TRI    = 2'd2,
    SQR    = 2'd3
  } mode_e;

  localparam int               WX    = WIDTH + 1;
  localparam logic [WIDTH:0]   MAX_X = WX'(MAX);
  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX);

  mode_e            mode_q, mode_d, req_mode;
  logic [WIDTH-1:0] wave_q, wave_d;
  logic             wrap_q, wrap_d;
  logic             dir_dn_q, dir_dn_d;
  logic [WIDTH:0]   s_x, wave_x, sum_x;
`ifdef TWG_SQUARE_EN
  logic             ph_q, ph_d;
  logic [WIDTH-1:0] hc_q, hc_d;
  logic [WIDTH:0]   hc_sum;
`endif

  // Zero step is promoted to one so every shape keeps moving.
  assign s_x    = (step == '0) ? WX'(1) : {1'b0, step};
  assign wave_x = {1'b0, wave_q};
  assign sum_x  = wave_x + s_x;

`ifdef TWG_SQUARE_EN
  assign req_mode = mode_e'(mode);
  assign hc_sum   = {1'b0, hc_q} + s_x;
`else
  assign req_mode = (mode == 2'd3) ? SAW_UP : mode_e'(mode);
`endif

  always_comb begin
    wave_d   = wave_q;
    dir_dn_d = dir_dn_q;
    mode_d   = mode_q;
    wrap_d   = 1'b0;
`ifdef TWG_SQUARE_EN
    ph_d     = ph_q;
    hc_d     = hc_q;
`endif
    if (enable) begin
      case (mode_q)
        SAW_DN: begin
          if (wave_x < s_x) begin
            wave_d = MAX_W;
            wrap_d = 1'b1;
          end else begin
            wave_d = WIDTH'(wave_x - s_x);
          end
        end
        TRI: begin
          if (!dir_dn_q) begin
            if (sum_x >= MAX_X) begin
              wave_d   = MAX_W;
              dir_dn_d = 1'b1;
            end else begin
              wave_d = sum_x[WIDTH-1:0];
            end
          end else if (wave_x <= s_x) begin
            wave_d   = '0;
            dir_dn_d = 1'b0;
            wrap_d   = 1'b1;
          end else begin
            wave_d = WIDTH'(wave_x - s_x);
          end
        end
`ifdef TWG_SQUARE_EN
        SQR: begin
          if (hc_sum > MAX_X) begin
            hc_d   = '0;
            ph_d   = ~ph_q;
            wrap_d = ph_q;
          end else begin
            hc_d = hc_sum[WIDTH-1:0];
          end
          wave_d = ph_d ? MAX_W : '0;
        end
`endif
        default: begin
          if (sum_x > MAX_X) begin
            wave_d = '0;
            wrap_d = 1'b1;
          end else begin
            wave_d = sum_x[WIDTH-1:0];
          end
        end
      endcase

      // A pending shape request replaces the normal wrap value with the new shape's start point.
      if (wrap_d && (req_mode != mode_q)) begin
        mode_d   = req_mode;
        wave_d   = (req_mode == SAW_DN) ? MAX_W : '0;
        dir_dn_d = 1'b0;
`ifdef TWG_SQUARE_EN
        ph_d     = 1'b0;
        hc_d     = '0;
`endif
      end
    end
  end

  always_ff @(posedge slowclock or posedge reset) begin
    if (reset) begin
      mode_q   <= SAW_UP;
      wave_q   <= '0;
      wrap_q   <= 1'b0;
      dir_dn_q <= 1'b0;
`ifdef TWG_SQUARE_EN
      ph_q     <= 1'b0;
      hc_q     <= '0;
`endif
    end else begin
      mode_q   <= mode_d;
      wave_q   <= wave_d;
      wrap_q   <= wrap_d;
      dir_dn_q <= dir_dn_d;
`ifdef TWG_SQUARE_EN
      ph_q     <= ph_d;
      hc_q     <= hc_d;
`endif
    end
  end

  assign wave        = wave_q;
  assign wrap        = wrap_q;
  assign mode_active = mode_q;

endmodule

`default_nettype wire

// File: tb/tb_test_wave_gen_multi.sv
// tb_test_wave_gen_multi: directed and randomized checks of test_wave_gen_multi against an integer reference model.
`default_nettype none

module tb_test_wave_gen_multi;

  localparam int WIDTH = 10;
  localparam int MAX   = 639;

  logic             slowclock;
  logic             reset;
  logic             enable;
  logic [1:0]       mode;
  logic [WIDTH-1:0] step;
  logic [WIDTH-1:0] wave;
  logic             wrap;
  logic [1:0]       mode_active;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state, expressed directly in the shape rules.
  int m_wave, m_dir_dn, m_ph, m_hc, m_mode, m_wrap;

  test_wave_gen_multi #(.WIDTH(WIDTH), .MAX(MAX)) dut (
    .slowclock   (slowclock),
    .reset       (reset),
    .enable      (enable),
    .mode        (mode),
    .step        (step),
    .wave        (wave),
    .wrap        (wrap),
    .mode_active (mode_active)
  );

  initial begin
    slowclock = 1'b0;
    forever #5 slowclock = ~slowclock;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wave = 0; m_dir_dn = 0; m_ph = 0; m_hc = 0; m_mode = 0; m_wrap = 0;
  endtask

  task automatic model_step();
    int s;
    int req;
    m_wrap = 0;
    if (!enable) return;
    s   = (step == 0) ? 1 : int'(step);
    req = int'(mode);
`ifndef TWG_SQUARE_EN
    if (req == 3) req = 0;
`endif
    case (m_mode)
      1: begin
        if (m_wave < s) begin m_wave = MAX; m_wrap = 1; end
        else m_wave = m_wave - s;
      end
      2: begin
        if (m_dir_dn == 0) begin
          if (m_wave + s >= MAX) begin m_wave = MAX; m_dir_dn = 1; end
          else m_wave = m_wave + s;
        end else begin
          if (m_wave <= s) begin m_wave = 0; m_dir_dn = 0; m_wrap = 1; end
          else m_wave = m_wave - s;
        end
      end
      3: begin
        if (m_hc + s > MAX) begin
          m_hc = 0;
          if (m_ph == 1) m_wrap = 1;
          m_ph = 1 - m_ph;
        end else m_hc = m_hc + s;
        m_wave = (m_ph == 1) ? MAX : 0;
      end
      default: begin
        if (m_wave + s > MAX) begin m_wave = 0; m_wrap = 1; end
        else m_wave = m_wave + s;
      end
    endcase
    if (m_wrap == 1 && req != m_mode) begin
      m_mode = req; m_dir_dn = 0; m_ph = 0; m_hc = 0;
      m_wave = (req == 1) ? MAX : 0;
    end
  endtask

  // One clock: advance the model with the inputs present at the edge, then compare 1 time unit later.
  task automatic cycle();
    if (reset) model_reset();
    else model_step();
    @(posedge slowclock);
    #1;
    check("wave", int'(wave), m_wave);
    check("wrap", int'(wrap), m_wrap);
    check("mode_active", int'(mode_active), m_mode);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_until_wave(input int v, input int budget);
    int n = 0;
    while (int'(wave) != v && n < budget) begin cycle(); n++; end
    if (n >= budget) check("wait_wave", int'(wave), v);
  endtask

  task automatic run_until_mode(input int v, input int budget);
    int n = 0;
    while (int'(mode_active) != v && n < budget) begin cycle(); n++; end
    if (n >= budget) check("wait_mode", int'(mode_active), v);
  endtask

  task automatic wait_wrap(input int budget);
    int n = 0;
    do begin cycle(); n++; end while (!wrap && n < budget);
    if (!wrap) check("wait_wrap", int'(wrap), 1);
  endtask

  task automatic measure_period(input string tag, input int exp);
    int n = 0;
    wait_wrap(3000);
    do begin cycle(); n++; end while (!wrap && n < 3000);
    check(tag, n, exp);
  endtask

  task automatic async_reset();
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("rst_async_wave", int'(wave), 0);
    check("rst_async_wrap", int'(wrap), 0);
    check("rst_async_mode", int'(mode_active), 0);
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 2'd0; step = 10'd1;
    model_reset();
    run(3);
    reset = 1'b0;
    run(2);

    // Saw up, step 1: period 640 with wrap on the 0 sample.
    enable = 1'b1;
    cycle();
    check("first_sample", int'(wave), 1);
    measure_period("period_saw_up", 640);

    // Large step, then zero step promoted to one.
    step = 10'd200;
    run_until_wave(0, 1000);
    run(6);
    step = 10'd0;
    run(5);

    // Triangle request at wave 300 waits for the saw wrap.
    step = 10'd1;
    run_until_wave(300, 1000);
    mode = 2'd2;
    run_until_mode(2, 1000);
    check("tri_start", int'(wave), 0);
    measure_period("period_tri", 1278);

    // Square request.
    mode = 2'd3;
    wait_wrap(3000);
`ifdef TWG_SQUARE_EN
    check("sqr_mode", int'(mode_active), 3);
    measure_period("period_sqr", 1280);
`else
    check("sqr_mode", int'(mode_active), 0);
    measure_period("period_sqr", 640);
`endif

    // Enable hold at 123.
    mode = 2'd0;
    wait_wrap(3000);
    run_until_wave(123, 1000);
    enable = 1'b0;
    run(50);
    enable = 1'b1;
    cycle();
    check("resume", int'(wave), 124);

    // Async reset mid-triangle descent.
    mode = 2'd2;
    run_until_mode(2, 1000);
    run_until_wave(639, 1000);
    run_until_wave(400, 1000);
    async_reset();
    step = 10'd5;
    cycle();
    check("restart_sample", int'(wave), 5);

    // Randomized run.
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0)
        step = ($urandom_range(0, 3) == 0) ? WIDTH'($urandom_range(0, 1023))
                                           : WIDTH'($urandom_range(0, 20));
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 999) == 0) async_reset();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
